alu_arbiter: RTL and testbench

- Shares the single combinational 16-bit ALU (operands a/b, 3-bit alu_control, result, zero flag) between two requesters, e.g. the CPU execute stage and an address-generation unit.
- Arbitrates round-robin and accepts one operation at a time with a valid/ready handshake.
- Drives the ALU from registered operands, captures the result and zero flag, and returns them on a response channel tagged with the requester id.
- Sits between the requesters and the ALU instance in the CPU top level.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/rr_arbiter2.sv | 14 +
 rtl/alu_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: datapath width, FSM state codes, ALU op encodings.
package cpu_pkg;

  localparam int WIDTH = 16;
  localparam int OPW   = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_EXEC = ST_EXEC,
    S_RESP = ST_RESP
  } arb_state_t;

  // Function selects shared by the ALU, the decoder and this arbiter.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-input round-robin grant; the caller owns the last-grant flop.
module rr_arbiter2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  output logic grant,
  output logic grant_id
);

  assign grant    = valid0 | valid1;
  // On contention the requester that did not win last time goes first.
  assign grant_id = (valid0 & valid1) ? ~last : valid1;

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one combinational ALU between two requesters.
// Optional grant/stall counters are built when ALU_ARB_STATS_EN is defined.
module alu_arbiter
  import cpu_pkg::*;
#(
  parameter int WIDTH = cpu_pkg::WIDTH,
  parameter int OPW   = cpu_pkg::OPW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_id,
`ifdef ALU_ARB_STATS_EN
  output logic [15:0]      grant0_cnt,
  output logic [15:0]      grant1_cnt,
  output logic [15:0]      stall_cnt,
`endif
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  arb_state_t       state_q;
  logic             rr_last_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [OPW-1:0]   op_q;
  logic             id_q, zero_q, rsp_valid_q;
  logic             grant, grant_id, take;
  logic [WIDTH-1:0] a_d, b_d;
  logic [OPW-1:0]   op_d;

  rr_arbiter2 u_rr (
    .valid0   (req0_valid),
    .valid1   (req1_valid),
    .last     (rr_last_q),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign take       = (state_q == S_IDLE) && grant;
  assign req0_ready = take && !grant_id && req0_valid;
  assign req1_ready = take &&  grant_id && req1_valid;

  assign a_d  = grant_id ? req1_a  : req0_a;
  assign b_d  = grant_id ? req1_b  : req0_b;
  assign op_d = grant_id ? req1_op : req0_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_last_q   <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      id_q        <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant) begin
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            id_q      <= grant_id;
            rr_last_q <= grant_id;
            state_q   <= S_EXEC;
          end
        end
        S_EXEC: begin
          result_q    <= alu_result;
          zero_q      <= alu_zero;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  // The ALU is fed only from the latched operands, so it stays quiet in IDLE.
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_control = op_q;

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_id     = id_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant0_cnt_q, grant1_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant0_cnt_q <= '0;
      grant1_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (take && !grant_id) grant0_cnt_q <= grant0_cnt_q + 16'd1;
      if (take &&  grant_id) grant1_cnt_q <= grant1_cnt_q + 16'd1;
      if (state_q == S_RESP && !rsp_ready && stall_cnt_q != 16'hffff)
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign grant0_cnt = grant0_cnt_q;
  assign grant1_cnt = grant1_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter with a behavioural ALU.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_zero, rsp_id;
  logic [15:0] rsp_result, alu_a, alu_b, alu_result;
  logic [2:0]  alu_control;
  logic        alu_zero;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant0_cnt, grant1_cnt, stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (alu_control)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = alu_a ^ alu_b;
      3'b101:  alu_result = alu_a << alu_b[3:0];
      3'b110:  alu_result = alu_a >> alu_b[3:0];
      default: alu_result = {15'd0, $signed(alu_a) < $signed(alu_b)};
    endcase
  end
  assign alu_zero = (alu_result == 16'd0);

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_id(rsp_id),
`ifdef ALU_ARB_STATS_EN
    .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt), .stall_cnt(stall_cnt),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = 0; req0_b = 0; req0_op = 0;
    req1_a = 0; req1_b = 0; req1_op = 0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Issue one request, wait for its response, hold backpressure for 'stall' edges, then consume it.
  task automatic do_op(input bit id, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                       input int stall, output logic [15:0] res, output logic z, output logic rid,
                       output bit ok);
    bit got;
    got = 0; ok = 0; rsp_ready = 0;
    if (id) begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1; end
    else    begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1; end
    #1;
    for (int i = 0; i < 10 && !got; i++) begin
      if (id ? req1_ready : req0_ready) got = 1;
      step();
    end
    req0_valid = 0; req1_valid = 0;
    if (got) begin
      for (int i = 0; i < 10 && !ok; i++) begin
        if (rsp_valid) ok = 1;
        else step();
      end
    end
    repeat (stall) step();
    res = rsp_result; z = rsp_zero; rid = rsp_id;
    rsp_ready = 1;
    step();
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_result !== 16'h0) begin n_bad++; $display("FAIL reset_rsp_result got %h want 0000", rsp_result); end
    n_cmp++; if ({rsp_id, rsp_zero} !== 2'b00) begin n_bad++; $display("FAIL reset_rsp_id_zero got %b want 00", {rsp_id, rsp_zero}); end
    n_cmp++; if ({alu_a, alu_b, alu_control} !== 35'h0) begin n_bad++; $display("FAIL reset_alu_outs got %h want 0", {alu_a, alu_b, alu_control}); end
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_ready_idle got %b want 00", {req0_ready, req1_ready}); end
  endtask

  task automatic test_single();
    req0_a = 16'd4; req0_b = 16'd2; req0_op = 3'b000; req0_valid = 1;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL single_ready got %b want 10", {req0_ready, req1_ready}); end
    step();
    req0_valid = 0;
    n_cmp++; if ({alu_a, alu_b, alu_control} !== {16'd4, 16'd2, 3'b000}) begin n_bad++; $display("FAIL single_exec_alu got %h/%h/%b want 0004/0002/000", alu_a, alu_b, alu_control); end
    n_cmp++; if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin n_bad++; $display("FAIL single_exec_ctl got %b want 000", {rsp_valid, req0_ready, req1_ready}); end
    step();
    n_cmp++; if ({rsp_valid, rsp_id, rsp_zero, rsp_result} !== {3'b100, 16'd6}) begin n_bad++; $display("FAIL single_rsp got v%b id%b z%b %h want v1 id0 z0 0006", rsp_valid, rsp_id, rsp_zero, rsp_result); end
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_rsp_drop got %b want 0", rsp_valid); end
    n_cmp++; if ({alu_a, alu_b} !== {16'd4, 16'd2}) begin n_bad++; $display("FAIL single_idle_alu_hold got %h/%h want 0004/0002", alu_a, alu_b); end
  endtask

  task automatic test_round_robin();
    logic        ids [4];
    logic [15:0] res [4];
    int got = 0;
    apply_reset();
    req0_a = 16'd10; req0_b = 16'd3; req0_op = 3'b001;
    req1_a = 16'd5;  req1_b = 16'd8; req1_op = 3'b011;
    req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    for (int i = 0; i < 40 && got < 4; i++) begin
      step();
      if (rsp_valid) begin ids[got] = rsp_id; res[got] = rsp_result; got++; end
    end
    req0_valid = 0; req1_valid = 0;
    step();
    rsp_ready = 0;
    n_cmp++; if (got !== 4) begin n_bad++; $display("FAIL rr_count got %0d want 4", got); end
    for (int i = 0; i < got; i++) begin
      n_cmp++; if (ids[i] !== 1'(i % 2)) begin n_bad++; $display("FAIL rr_id[%0d] got %b want %0d", i, ids[i], i % 2); end
      n_cmp++; if (res[i] !== ((i % 2) ? 16'h000d : 16'h0007)) begin n_bad++; $display("FAIL rr_result[%0d] got %h want %h", i, res[i], (i % 2) ? 16'h000d : 16'h0007); end
    end
  endtask

  task automatic test_backpressure();
    bit seen = 0;
    req0_a = 16'd1; req0_b = 16'd2; req0_op = 3'b000; req0_valid = 1; rsp_ready = 0;
    #1;
    step();
    req0_valid = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (rsp_valid) seen = 1; else step();
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL bp_timeout got no rsp_valid want rsp_valid=1"); end
    req1_a = 16'd9; req1_b = 16'd9; req1_op = 3'b100; req1_valid = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if ({rsp_valid, rsp_id, rsp_result, req0_ready, req1_ready} !== {2'b10, 16'd3, 2'b00})
        begin n_bad++; $display("FAIL bp_hold[%0d] got v%b id%b %h rdy%b%b want v1 id0 0003 rdy00", i, rsp_valid, rsp_id, rsp_result, req0_ready, req1_ready); end
      step();
    end
    rsp_ready = 1;
    step();
    n_cmp++; if ({rsp_valid, req1_ready} !== 2'b01) begin n_bad++; $display("FAIL bp_release got v%b rdy1%b want v0 rdy1 1", rsp_valid, req1_ready); end
    step();
    req1_valid = 0;
    step();
    step();
    rsp_ready = 0;
  endtask

  task automatic test_zero();
    logic [15:0] r; logic z, id; bit ok;
    do_op(1'b1, 16'd4, 16'd4, 3'b001, 0, r, z, id, ok);
    n_cmp++; if ({ok, id, z, r} !== {3'b111, 16'h0000}) begin n_bad++; $display("FAIL zero_sub got ok%b id%b z%b %h want ok1 id1 z1 0000", ok, id, z, r); end
    do_op(1'b1, 16'hff0f, 16'h0000, 3'b010, 0, r, z, id, ok);
    n_cmp++; if ({ok, id, z, r} !== {3'b111, 16'h0000}) begin n_bad++; $display("FAIL zero_and got ok%b id%b z%b %h want ok1 id1 z1 0000", ok, id, z, r); end
    do_op(1'b1, 16'hff0f, 16'h0000, 3'b011, 0, r, z, id, ok);
    n_cmp++; if ({ok, id, z, r} !== {3'b110, 16'hff0f}) begin n_bad++; $display("FAIL zero_or got ok%b id%b z%b %h want ok1 id1 z0 ff0f", ok, id, z, r); end
  endtask

  task automatic test_reset_mid();
    req0_a = 16'd7; req0_b = 16'd9; req0_op = 3'b100; req0_valid = 1;
    #1;
    step();
    req0_valid = 0;
    n_cmp++; if (alu_a !== 16'd7) begin n_bad++; $display("FAIL mid_exec_alu_a got %h want 0007", alu_a); end
    reset = 1'b1;
    #1;
    n_cmp++; if ({rsp_valid, alu_a, alu_b, alu_control} !== 36'h0) begin n_bad++; $display("FAIL mid_reset_async got v%b %h/%h/%b want all 0", rsp_valid, alu_a, alu_b, alu_control); end
    step();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_hold got %b want 0", rsp_valid); end
    reset = 1'b0;
    step();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_after_release got %b want 0", rsp_valid); end
    req0_valid = 1; req1_valid = 1;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL mid_first_grant got %b want 10", {req0_ready, req1_ready}); end
    req0_valid = 0; req1_valid = 0;
    step();
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    logic [15:0] r; logic z, id; bit ok;
    apply_reset();
    n_cmp++; if ({grant0_cnt, grant1_cnt, stall_cnt} !== 48'h0) begin n_bad++; $display("FAIL stats_reset got %h/%h/%h want 0/0/0", grant0_cnt, grant1_cnt, stall_cnt); end
    do_op(1'b0, 16'd1, 16'd1, 3'b000, 4, r, z, id, ok);
    do_op(1'b0, 16'd2, 16'd1, 3'b000, 0, r, z, id, ok);
    do_op(1'b0, 16'd3, 16'd1, 3'b000, 0, r, z, id, ok);
    do_op(1'b1, 16'd4, 16'd1, 3'b000, 0, r, z, id, ok);
    do_op(1'b1, 16'd5, 16'd1, 3'b000, 0, r, z, id, ok);
    n_cmp++; if (grant0_cnt !== 16'd3) begin n_bad++; $display("FAIL stats_grant0 got %0d want 3", grant0_cnt); end
    n_cmp++; if (grant1_cnt !== 16'd2) begin n_bad++; $display("FAIL stats_grant1 got %0d want 2", grant1_cnt); end
    n_cmp++; if (stall_cnt !== 16'd4) begin n_bad++; $display("FAIL stats_stall got %0d want 4", stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_zero();
    test_reset_mid();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
